// File: rtl/ifm_pkg.sv
// Shared types and constants for the instruction fetch/prefetch unit.
package ifm_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] IRQ_VECTOR_DEF   = 32'h0000_0010;
  localparam logic [XLEN-1:0] DRQ_VECTOR_DEF   = 32'h0000_0800;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCHING = 2'd1,
    DRAINING = 2'd2
  } ifm_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } ifm_entry_t;

  localparam int unsigned ENTRY_W = $bits(ifm_entry_t);

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifm_fifo.sv
// Synchronous FIFO with flush; depth must be a power of two so pointers wrap naturally.
module ifm_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Flush wins over any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ifm_prefetch.sv
// Prefetching instruction fetch unit: pipelined Wishbone reads into a credit-limited FIFO,
// with prioritised redirects that flush the FIFO and drain in-flight responses.
module ifm_prefetch
  import ifm_pkg::*;
#(
  parameter int unsigned FETCH_DEPTH   = 4,
  parameter int unsigned BOFFSET_WIDTH = 20,
  parameter logic [31:0] RESET_VECTOR  = RESET_VECTOR_DEF,
  parameter logic [31:0] IRQ_VECTOR    = IRQ_VECTOR_DEF,
  parameter logic [31:0] DRQ_VECTOR    = DRQ_VECTOR_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     irq_i,
  input  logic                     drq_i,
  input  logic                     branch_i,
  input  logic [BOFFSET_WIDTH-1:0] boffset_i,
  output logic [31:0]              wb_adr_o,
  input  logic [31:0]              wb_dat_i,
  output logic [3:0]               wb_sel_o,
  output logic                     wb_we_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  input  logic                     wb_stall_i,
  input  logic                     wb_ack_i,
  input  logic                     output_ready_i,
  output logic                     output_valid_o,
  output logic [31:0]              instr_o,
  output logic [31:0]              pc_o
);

  localparam int unsigned CNT_W = $clog2(FETCH_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  ifm_state_e       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [31:0]      last_pc_q, last_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  ifm_entry_t       head;
  ifm_entry_t       push_entry;
  logic             redirect, stb, accept, ack_ok, push, pop, flush;
  logic [31:0]      target_raw, target;

  ifm_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FETCH_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .flush_i (flush),
    .rdata_o (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // Redirect target: debug over interrupt over branch; branch base is the last delivered pc.
  always_comb begin
    target_raw = last_pc_q + 32'($signed(boffset_i));
    if (drq_i)      target_raw = DRQ_VECTOR;
    else if (irq_i) target_raw = IRQ_VECTOR;
  end

  assign target   = word_align(target_raw);
  assign redirect = drq_i | irq_i | branch_i;

  // Credit rule: buffered plus in-flight never exceeds the FIFO depth.
  assign stb    = (state_q == FETCHING) &&
                  ((SUM_W'(fifo_count) + SUM_W'(outstanding_q)) < SUM_W'(FETCH_DEPTH));
  assign accept = stb & ~wb_stall_i;
  assign ack_ok = wb_ack_i & (outstanding_q != '0);
  assign pop    = ~fifo_empty & output_ready_i;

  assign push_entry.instr = wb_dat_i;
  assign push_entry.pc    = resp_pc_q;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    last_pc_d     = last_pc_q;
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(ack_ok);
    push          = 1'b0;
    flush         = 1'b0;

    if (pop) last_pc_d = head.pc;

    unique case (state_q)
      IDLE: state_d = FETCHING;
      FETCHING: begin
        if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
        if (ack_ok) begin
          push      = 1'b1;
          resp_pc_d = resp_pc_q + 32'd4;
        end
      end
      DRAINING: begin
        if (outstanding_d == '0) state_d = FETCHING;
      end
      default: state_d = IDLE;
    endcase

    // Latest redirect wins; responses still in flight are discarded while draining.
    if (redirect) begin
      state_d    = DRAINING;
      fetch_pc_d = target;
      resp_pc_d  = target;
      flush      = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      fetch_pc_q    <= word_align(RESET_VECTOR);
      resp_pc_q     <= word_align(RESET_VECTOR);
      last_pc_q     <= RESET_VECTOR;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      last_pc_q     <= last_pc_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign wb_stb_o       = stb;
  assign wb_cyc_o       = stb | (outstanding_q != '0);
  assign wb_sel_o       = stb ? 4'hF : 4'h0;
  assign wb_we_o        = 1'b0;
  assign wb_adr_o       = (state_q == FETCHING) ? fetch_pc_q : 32'h0;
  assign output_valid_o = ~fifo_empty;
  assign instr_o        = fifo_empty ? 32'h0 : head.instr;
  assign pc_o           = fifo_empty ? 32'h0 : head.pc;

endmodule

// File: tb/tb_ifm_prefetch.sv
// Directed bench for ifm_prefetch with a pipelined Wishbone slave model of configurable latency.
module tb_ifm_prefetch;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        irq_i = 1'b0;
  logic        drq_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [19:0] boffset_i = '0;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_stall_i = 1'b0;
  logic        wb_ack_i = 1'b0;
  logic        output_ready_i = 1'b0;
  logic        output_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  always #5 clk_i = ~clk_i;

  ifm_prefetch dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .irq_i          (irq_i),
    .drq_i          (drq_i),
    .branch_i       (branch_i),
    .boffset_i      (boffset_i),
    .wb_adr_o       (wb_adr_o),
    .wb_dat_i       (wb_dat_i),
    .wb_sel_o       (wb_sel_o),
    .wb_we_o        (wb_we_o),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_stall_i     (wb_stall_i),
    .wb_ack_i       (wb_ack_i),
    .output_ready_i (output_ready_i),
    .output_valid_o (output_valid_o),
    .instr_o        (instr_o),
    .pc_o           (pc_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave: responses in request order, data = address ^ salt, ack lat cycles after acceptance.
  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t        pend[$];
  logic [31:0] acc_q[$];
  logic [31:0] dq_pc[$];
  logic [31:0] dq_in[$];
  int          cyc  = 0;
  int          lat  = 1;
  bit          hold = 1'b0;
  logic [31:0] salt = '0;

  always @(posedge clk_i) begin
    rsp_t r;
    if (rst_i && wb_stb_o && !wb_stall_i) begin
      r.data = wb_adr_o ^ salt;
      r.due  = cyc + lat;
      pend.push_back(r);
      acc_q.push_back(wb_adr_o);
    end
    if (output_valid_o && output_ready_i) begin
      dq_pc.push_back(pc_o);
      dq_in.push_back(instr_o);
    end
    cyc++;
    #1;
    if (!hold && pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      wb_ack_i = 1'b1;
      wb_dat_i = r.data;
    end else begin
      wb_ack_i = 1'b0;
      wb_dat_i = '0;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(output_valid_o), 32'd0);
    chk({tag, "_stb"},   32'({wb_stb_o, wb_cyc_o, wb_we_o}), 32'd0);
    chk({tag, "_sel"},   32'(wb_sel_o), 32'd0);
    chk({tag, "_adr"},   wb_adr_o, 32'd0);
    chk({tag, "_instr"}, instr_o, 32'd0);
    chk({tag, "_pc"},    pc_o, 32'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    irq_i = 1'b0; drq_i = 1'b0; branch_i = 1'b0; boffset_i = '0;
    wb_stall_i = 1'b0; output_ready_i = 1'b0;
    hold = 1'b0; salt = '0; lat = 1;
    pend.delete(); acc_q.delete(); dq_pc.delete(); dq_in.delete();
    step(2);
    chk_idle_outputs("rst");
    rst_i = 1'b1;
  endtask

  task automatic wait_deliv(input string tag, input int n);
    int k = 0;
    while (dq_pc.size() < n && k < 200) begin step(); k++; end
    chk(tag, 32'(dq_pc.size() >= n), 32'd1);
  endtask

  task automatic wait_acc(input string tag, input int n);
    int k = 0;
    while (acc_q.size() < n && k < 200) begin step(); k++; end
    chk(tag, 32'(acc_q.size() >= n), 32'd1);
  endtask

  initial begin
    int na, nd, k;

    // 1: zero-wait slave, first valid three cycles after release
    do_reset();
    output_ready_i = 1'b1;
    chk("t1_c0_stb", 32'(wb_stb_o), 32'd0);
    step();
    chk("t1_c1_stb", 32'(wb_stb_o), 32'd1);
    chk("t1_c1_adr", wb_adr_o, 32'h0);
    chk("t1_c1_sel", 32'(wb_sel_o), 32'hF);
    chk("t1_c1_valid", 32'(output_valid_o), 32'd0);
    step();
    chk("t1_c2_adr", wb_adr_o, 32'h4);
    chk("t1_c2_valid", 32'(output_valid_o), 32'd0);
    step();
    chk("t1_c3_adr", wb_adr_o, 32'h8);
    chk("t1_c3_valid", 32'(output_valid_o), 32'd1);
    chk("t1_c3_pc", pc_o, 32'h0);
    wait_deliv("t1_wait", 3);
    chk("t1_pc1", dq_pc[1], 32'h4);
    chk("t1_pc2", dq_pc[2], 32'h8);
    chk("t1_in2", dq_in[2], 32'h8);

    // 2: decoder stalled, credit limit stops requests at depth
    do_reset();
    lat = 2;
    step(12);
    chk("t2_nacc", 32'(acc_q.size()), 32'd4);
    chk("t2_acc3", acc_q[3], 32'hC);
    chk("t2_stb", 32'(wb_stb_o), 32'd0);
    chk("t2_cyc", 32'(wb_cyc_o), 32'd0);
    chk("t2_valid", 32'(output_valid_o), 32'd1);
    chk("t2_head", pc_o, 32'h0);
    output_ready_i = 1'b1;
    wait_deliv("t2_wait", 5);
    chk("t2_pc3", dq_pc[3], 32'hC);
    chk("t2_pc4", dq_pc[4], 32'h10);
    chk("t2_acc4", acc_q[4], 32'h10);

    // 3: branch -8 right after 0x10 delivered, slow slave leaves reads in flight
    do_reset();
    lat = 3;
    output_ready_i = 1'b1;
    k = 0;
    while (dq_pc.size() < 5 && k < 100) begin step(); k++; end
    chk("t3_pre", dq_pc[4], 32'h10);
    branch_i = 1'b1; boffset_i = 20'hFFFF8;
    step();
    branch_i = 1'b0; boffset_i = '0;
    chk("t3_drain_stb", 32'(wb_stb_o), 32'd0);
    chk("t3_drain_valid", 32'(output_valid_o), 32'd0);
    na = acc_q.size(); nd = dq_pc.size();
    wait_acc("t3_wacc", na + 1);
    chk("t3_acc", acc_q[na], 32'h8);
    wait_deliv("t3_wdq", nd + 1);
    chk("t3_pc", dq_pc[nd], 32'h8);
    chk("t3_in", dq_in[nd], 32'h8);

    // 4a: irq beats branch in the same cycle
    do_reset();
    output_ready_i = 1'b1;
    step(4);
    irq_i = 1'b1; branch_i = 1'b1; boffset_i = 20'h00100;
    step();
    irq_i = 1'b0; branch_i = 1'b0; boffset_i = '0;
    na = acc_q.size(); nd = dq_pc.size();
    wait_acc("t4a_wacc", na + 1);
    chk("t4a_acc", acc_q[na], 32'h10);
    wait_deliv("t4a_wdq", nd + 1);
    chk("t4a_pc", dq_pc[nd], 32'h10);

    // 4b: irq+branch, then drq while draining replaces the target
    irq_i = 1'b1; branch_i = 1'b1;
    step();
    irq_i = 1'b0; branch_i = 1'b0; drq_i = 1'b1;
    step();
    drq_i = 1'b0;
    na = acc_q.size(); nd = dq_pc.size();
    wait_acc("t4b_wacc", na + 1);
    chk("t4b_acc", acc_q[na], 32'h800);
    wait_deliv("t4b_wdq", nd + 1);
    chk("t4b_pc", dq_pc[nd], 32'h800);
    chk("t4b_in", dq_in[nd], 32'h800);

    // 5: branch from last_pc 0 by -3: aligned target 0xFFFFFFFC, then wrap to 0
    do_reset();
    output_ready_i = 1'b1;
    step();
    branch_i = 1'b1; boffset_i = 20'hFFFFD;
    step();
    branch_i = 1'b0; boffset_i = '0;
    na = acc_q.size(); nd = dq_pc.size();
    wait_acc("t5_wacc", na + 2);
    chk("t5_acc0", acc_q[na], 32'hFFFF_FFFC);
    chk("t5_acc1", acc_q[na+1], 32'h0);
    wait_deliv("t5_wdq", nd + 2);
    chk("t5_pc0", dq_pc[nd], 32'hFFFF_FFFC);
    chk("t5_pc1", dq_pc[nd+1], 32'h0);

    // 6: stall held five cycles with strobe up
    do_reset();
    wb_stall_i = 1'b1;
    output_ready_i = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t6_adr", wb_adr_o, 32'h0);
      chk("t6_stb", 32'(wb_stb_o), 32'd1);
      chk("t6_valid", 32'(output_valid_o), 32'd0);
      step();
    end
    chk("t6_nacc", 32'(acc_q.size()), 32'd0);
    wb_stall_i = 1'b0;
    wait_deliv("t6_wdq", 1);
    chk("t6_pc", dq_pc[0], 32'h0);

    // 7: reset with three reads in flight, stale acks after release are ignored
    do_reset();
    hold = 1'b1;
    salt = 32'hDEAD_0000;
    k = 0;
    while (acc_q.size() < 3 && k < 50) begin step(); k++; end
    wb_stall_i = 1'b1;
    chk("t7_nacc", 32'(acc_q.size()), 32'd3);
    chk("t7_cyc", 32'(wb_cyc_o), 32'd1);
    rst_i = 1'b0;
    step(2);
    chk_idle_outputs("t7_rst");
    rst_i = 1'b1;
    hold = 1'b0;
    dq_pc.delete(); dq_in.delete();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t7_stale_valid", 32'(output_valid_o), 32'd0);
    end
    salt = '0;
    na = acc_q.size();
    wb_stall_i = 1'b0;
    output_ready_i = 1'b1;
    wait_acc("t7_wacc", na + 1);
    chk("t7_acc", acc_q[na], 32'h0);
    wait_deliv("t7_wdq", 1);
    chk("t7_pc", dq_pc[0], 32'h0);
    chk("t7_in", dq_in[0], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
